// File: rtl/regfile_key_writer.sv
// -----------------------------------------------------------------------------
// regfile_key_writer
//
// Write front-end for a switch-driven register file. It turns a raw, bouncing,
// active-low push-button into exactly one clean, single-cycle write strobe per
// press. The address and data for that write are registered alongside the
// strobe.
//
// Optional feature macro: AUTO_INC_EN
//   defined   : wr_addr comes from an internal address pointer. The pointer
//               increments after every strobe and can be loaded from sw_addr
//               with addr_load.
//   undefined : wr_addr is captured from sw_addr and addr_load is ignored.
//
// Parameters
//   DATA_WIDTH       width of sw_data / wr_data
//   ADDR_WIDTH       width of sw_addr / wr_addr
//   DEBOUNCE_CYCLES  stable-level cycles required on press and release (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   key_n      in   raw push-button (0 = pressed), asynchronous to clk
//   sw_data    in   data to write
//   sw_addr    in   write address, or the pointer load value with AUTO_INC_EN
//   addr_load  in   load the address pointer from sw_addr (AUTO_INC_EN only)
//   wr_en      out  one-cycle write strobe
//   wr_addr    out  registered write address
//   wr_data    out  registered write data
//   busy       out  high whenever the FSM is not idle
//   wr_count   out  number of strobes issued, wraps modulo 256
// -----------------------------------------------------------------------------
module regfile_key_writer #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_n,
  input  logic [DATA_WIDTH-1:0] sw_data,
  input  logic [ADDR_WIDTH-1:0] sw_addr,
  input  logic                  addr_load,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic [7:0]            wr_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    FIRE     = 3'd2,
    HELD     = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            sync_meta_r;
  logic            key_s;
  logic [ADDR_WIDTH-1:0] fire_addr_s;

  // Two-flop synchronizer for the asynchronous button. The flops reset to the
  // released level so that reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_r <= 1'b1;
      key_s       <= 1'b1;
    end else begin
      sync_meta_r <= key_n;
      key_s       <= sync_meta_r;
    end
  end

`ifdef AUTO_INC_EN
  logic [ADDR_WIDTH-1:0] ptr_r;

  // Address pointer. In FIRE the increment takes priority over a load, so a
  // load request during the strobe cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (state_r == FIRE) begin
      ptr_r <= ptr_r + ADDR_WIDTH'(1);
    end else if (addr_load) begin
      ptr_r <= sw_addr;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign fire_addr_s = ptr_r;
`else
  logic unused_addr_load;
  assign unused_addr_load = addr_load;
  assign fire_addr_s      = sw_addr;
`endif

  // Debounce FSM. wr_en and busy are registered from the next state, so they
  // change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      wr_count <= 8'd0;
    end else begin
      wr_en <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!key_s) begin
            state_r <= DB_PRESS;
            cnt_r   <= '0;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        DB_PRESS: begin
          if (key_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= FIRE;
            cnt_r   <= '0;
            wr_en   <= 1'b1;
            wr_data <= sw_data;
            wr_addr <= fire_addr_s;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        FIRE: begin
          state_r  <= HELD;
          cnt_r    <= '0;
          wr_count <= wr_count + 8'd1;
        end
        HELD: begin
          if (key_s) begin
            state_r <= DB_REL;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        DB_REL: begin
          if (!key_s) begin
            state_r <= HELD;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
